// File: rtl/white_pawn_push_sequencer_pkg.sv
// Shared chess constants and sequencer state encoding.
package white_pawn_push_sequencer_pkg;

  localparam int unsigned SQ_W = 6;

  localparam logic [63:0] RANK4_MASK = 64'h00000000FF000000;

  localparam logic [SQ_W-1:0] PROMO_SQ = 6'd56;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/White_Pawn_Push.sv
// White pawn push target sets: single pushes and rank-2 double pushes.
module White_Pawn_Push
  import white_pawn_push_sequencer_pkg::*;
(
  input  logic [63:0] occupied_i,
  input  logic [63:0] white_pawn_i,
  output logic [63:0] single_o,
  output logic [63:0] double_o
);

  // Shifts drop bits past square 63, so rank-8 pawns yield nothing.
  always_comb begin
    single_o = (white_pawn_i << 8) & ~occupied_i;
    double_o = (single_o << 8) & ~occupied_i & RANK4_MASK;
  end

endmodule

// File: rtl/lsb_index64.sv
// 64-bit lowest-set-bit priority encoder.
module lsb_index64 (
  input  logic [63:0] vec_i,
  output logic [5:0]  idx_o,
  output logic        nz_o
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    idx_o = '0;
    for (int unsigned i = 64; i > 0; i--) begin
      if (vec_i[i-1]) idx_o = 6'(i - 1);
    end
    nz_o = (vec_i != '0);
  end

endmodule

// File: rtl/white_pawn_push_sequencer.sv
// Serialises white pawn pushes into one move per valid/ready handshake.
module white_pawn_push_sequencer
  import white_pawn_push_sequencer_pkg::*;
#(
  parameter bit DOUBLE_EN     = 1'b1,
  parameter bit SINGLES_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] occupied,
  input  logic [63:0] white_pawn,
  output logic        busy,
  output logic        move_valid,
  input  logic        move_ready,
  output logic [5:0]  move_from,
  output logic [5:0]  move_to,
  output logic        move_double,
  output logic        move_promo,
  output logic        done,
  output logic [4:0]  move_count
);

  state_e      state_q, state_d;
  logic [63:0] single_q, single_d;
  logic [63:0] dbl_q, dbl_d;
  logic [4:0]  count_q, count_d;
  logic [4:0]  mcount_q, mcount_d;

  logic [63:0]     push_single, push_double;
  logic [63:0]     active;
  logic            use_single;
  logic [SQ_W-1:0] t;
  logic            t_nz;

  White_Pawn_Push u_push (
    .occupied_i   (occupied),
    .white_pawn_i (white_pawn),
    .single_o     (push_single),
    .double_o     (push_double)
  );

  // Pick which mask is being drained according to the emission order.
  always_comb begin
    use_single = SINGLES_FIRST ? (single_q != '0) : (dbl_q == '0);
    active     = use_single ? single_q : dbl_q;
  end

  lsb_index64 u_lsb (
    .vec_i (active),
    .idx_o (t),
    .nz_o  (t_nz)
  );

  // Move fields are derived from the registered masks; zero outside EMIT.
  always_comb begin
    move_valid  = (state_q == ST_EMIT) && t_nz;
    move_to     = move_valid ? t : '0;
    move_from   = '0;
    if (move_valid) move_from = use_single ? (t - 6'd8) : (t - 6'd16);
    move_double = move_valid && !use_single;
    move_promo  = move_valid && use_single && (t >= PROMO_SQ);
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_DONE);
    move_count  = mcount_q;
  end

  // Next-state logic: snapshot on start, drain on handshake, abort wins.
  always_comb begin
    state_d  = state_q;
    single_d = single_q;
    dbl_d    = dbl_q;
    count_d  = count_q;
    mcount_d = mcount_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          single_d = push_single;
          dbl_d    = DOUBLE_EN ? push_double : '0;
          count_d  = '0;
          if ((push_single | dbl_d) != '0) begin
            state_d = ST_EMIT;
          end else begin
            state_d  = ST_DONE;
            mcount_d = '0;
          end
        end
      end
      ST_EMIT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (move_valid && move_ready) begin
          if (use_single) single_d = single_q & (single_q - 64'd1);
          else            dbl_d    = dbl_q & (dbl_q - 64'd1);
          count_d = count_q + 5'd1;
          if ((single_d | dbl_d) == '0) begin
            state_d  = ST_DONE;
            mcount_d = count_q + 5'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      single_q <= '0;
      dbl_q    <= '0;
      count_q  <= '0;
      mcount_q <= '0;
    end else begin
      state_q  <= state_d;
      single_q <= single_d;
      dbl_q    <= dbl_d;
      count_q  <= count_d;
      mcount_q <= mcount_d;
    end
  end

endmodule
